reg_scoreboard: RTL and testbench

Parametrised register-hazard scoreboard for the pipelined core. It decodes issue-stage and writeback-stage destination addresses into one-hot per-register updates on a bank of saturating pending counters. It reports source-operand busy status and issue back-pressure to the stall logic. It generalises the fixed 5-to-32 destination decode to any address width and supports multiple outstanding writes per register, flush, and error flagging.

---
 rtl/reg_scoreboard.sv | 93 +++++++++
 tb/tb_reg_scoreboard.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: one saturating pending-write counter per register,
// driven by one-hot issue (increment) and writeback (decrement) decodes.
module reg_scoreboard #(
  parameter  int ADDR_W             = 5,
  parameter  int CNT_W              = 2,
  parameter  bit ZERO_REG_HARDWIRED = 1'b1,
  parameter  bit BYPASS_WB          = 1'b1,
  localparam int NUM_REGS           = 2 ** ADDR_W
) (
  input  logic                clock_i,
  input  logic                reset_ni,
  input  logic                flush_i,
  input  logic                issue_valid_i,
  input  logic [ADDR_W-1:0]   issue_rd_i,
  output logic                issue_ready_o,
  input  logic                wb_valid_i,
  input  logic [ADDR_W-1:0]   wb_rd_i,
  input  logic [ADDR_W-1:0]   rs1_addr_i,
  input  logic [ADDR_W-1:0]   rs2_addr_i,
  output logic                rs1_busy_o,
  output logic                rs2_busy_o,
  output logic [NUM_REGS-1:0] pending_vec_o,
  output logic                underflow_err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NUM_REGS-1:0][CNT_W-1:0] count_q;
  logic [NUM_REGS-1:0][CNT_W-1:0] count_d;
  logic [NUM_REGS-1:0]            inc_vec;
  logic [NUM_REGS-1:0]            dec_vec;
  logic [NUM_REGS-1:0]            uf_vec;
  logic                           underflow_q;
  logic                           underflow_d;
  logic                           issue_acc;

  // A same-cycle writeback to the issuing register frees the slot the issue needs.
  assign issue_ready_o = (ZERO_REG_HARDWIRED && (issue_rd_i == '0))
                      || (count_q[issue_rd_i] != CNT_MAX)
                      || (wb_valid_i && (wb_rd_i == issue_rd_i));
  assign issue_acc = issue_valid_i && issue_ready_o;

  function automatic logic src_busy(input logic [ADDR_W-1:0] rs);
    logic [CNT_W-1:0] c;
    logic             bypass;
    c      = count_q[rs];
    bypass = BYPASS_WB && wb_valid_i && (wb_rd_i == rs) && (c == CNT_ONE)
          && !(issue_acc && (issue_rd_i == rs));
    return (c != '0) && !(ZERO_REG_HARDWIRED && (rs == '0)) && !bypass;
  endfunction

  assign rs1_busy_o = src_busy(rs1_addr_i);
  assign rs2_busy_o = src_busy(rs2_addr_i);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (ZERO_REG_HARDWIRED && (gi == 0)) begin : g_zero
        assign inc_vec[gi] = 1'b0;
        assign dec_vec[gi] = 1'b0;
      end else begin : g_track
        assign inc_vec[gi] = issue_acc && (issue_rd_i == ADDR_W'(gi));
        assign dec_vec[gi] = wb_valid_i && (wb_rd_i == ADDR_W'(gi));
      end

      assign uf_vec[gi] = dec_vec[gi] && !inc_vec[gi] && (count_q[gi] == '0);

      // Inc and dec together cancel; a lone dec at zero holds the count.
      assign count_d[gi] = flush_i                              ? '0 :
                           (inc_vec[gi] && !dec_vec[gi])        ? count_q[gi] + CNT_ONE :
                           (dec_vec[gi] && !inc_vec[gi] && (count_q[gi] != '0))
                                                                ? count_q[gi] - CNT_ONE :
                                                                  count_q[gi];

      assign pending_vec_o[gi] = (count_q[gi] != '0);
    end
  endgenerate

  assign underflow_d     = underflow_q || (!flush_i && (|uf_vec));
  assign underflow_err_o = underflow_q;

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized and directed checking of reg_scoreboard against an integer-count model.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [31:0] pending_vec;
  logic        underflow_err;

  int n_cmp = 0;
  int n_bad = 0;

  int cnt [32];
  bit uf_m     = 1'b0;
  bit model_ok = 1'b0;

  always #5 clk = ~clk;

  reg_scoreboard #(
    .ADDR_W(5), .CNT_W(2), .ZERO_REG_HARDWIRED(1'b1), .BYPASS_WB(1'b1)
  ) dut (
    .clock_i        (clk),
    .reset_ni       (rst_n),
    .flush_i        (flush),
    .issue_valid_i  (issue_valid),
    .issue_rd_i     (issue_rd),
    .issue_ready_o  (issue_ready),
    .wb_valid_i     (wb_valid),
    .wb_rd_i        (wb_rd),
    .rs1_addr_i     (rs1_addr),
    .rs2_addr_i     (rs2_addr),
    .rs1_busy_o     (rs1_busy),
    .rs2_busy_o     (rs2_busy),
    .pending_vec_o  (pending_vec),
    .underflow_err_o(underflow_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit exp_busy(input int rs, input bit acc, input int ird,
                                  input bit wv, input int wrd);
    if (rs == 0) return 1'b0;
    if (cnt[rs] == 0) return 1'b0;
    if (wv && wrd == rs && cnt[rs] == 1 && !(acc && ird == rs)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step(input bit r_n, input bit fl, input bit iv, input int ird,
                      input bit wv, input int wrd, input int rs1, input int rs2);
    bit          rdy_e;
    bit          acc;
    int          nxt [32];
    bit          uf_n;
    logic [31:0] pv_e;
    @(negedge clk);
    rst_n       = r_n;
    flush       = fl;
    issue_valid = iv;
    issue_rd    = 5'(ird);
    wb_valid    = wv;
    wb_rd       = 5'(wrd);
    rs1_addr    = 5'(rs1);
    rs2_addr    = 5'(rs2);
    #1;
    rdy_e = (ird == 0) || (cnt[ird] < 3) || (wv && wrd == ird);
    acc   = iv && rdy_e;
    if (model_ok) begin
      check("issue_ready", 32'(issue_ready), 32'(rdy_e));
      check("rs1_busy", 32'(rs1_busy), 32'(exp_busy(rs1, acc, ird, wv, wrd)));
      check("rs2_busy", 32'(rs2_busy), 32'(exp_busy(rs2, acc, ird, wv, wrd)));
    end
    nxt  = cnt;
    uf_n = uf_m;
    if (!r_n) begin
      foreach (nxt[k]) nxt[k] = 0;
      uf_n = 1'b0;
    end else if (fl) begin
      foreach (nxt[k]) nxt[k] = 0;
    end else begin
      if (acc && ird != 0) nxt[ird]++;
      if (wv && wrd != 0) begin
        if (nxt[wrd] > 0) nxt[wrd]--;
        else uf_n = 1'b1;
      end
    end
    @(posedge clk);
    cnt      = nxt;
    uf_m     = uf_n;
    model_ok = 1'b1;
    #1;
    pv_e = '0;
    for (int k = 0; k < 32; k++) pv_e[k] = (cnt[k] != 0);
    check("pending_vec", pending_vec, pv_e);
    check("underflow_err", 32'(underflow_err), 32'(uf_m));
    $display("txn rst_n=%0b fl=%0b iv=%0b rd=%0d wv=%0b wrd=%0d rs=%0d/%0d rdy=%0b pv=%h uf=%0b",
             r_n, fl, iv, ird, wv, wrd, rs1, rs2, rdy_e, pending_vec, underflow_err);
  endtask

  initial begin
    foreach (cnt[k]) cnt[k] = 0;
    rst_n = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_rd = '0;
    wb_valid = 1'b0; wb_rd = '0; rs1_addr = '0; rs2_addr = '0;

    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("rst_pending", pending_vec, 32'h0);
    check("rst_ready", 32'(issue_ready), 32'd1);

    step(1, 0, 1, 7, 0, 0, 0, 0);
    check("pv_rd7", pending_vec, 32'h0000_0080);
    step(1, 0, 0, 0, 0, 0, 7, 0);
    check("rs1_busy_rd7", 32'(rs1_busy), 32'd1);

    // Fill rd3 to max, then try to exceed it with and without a freeing writeback.
    repeat (3) step(1, 0, 1, 3, 0, 0, 3, 0);
    step(1, 0, 1, 3, 0, 0, 3, 0);
    check("full_not_ready", 32'(issue_ready), 32'd0);
    step(1, 0, 1, 3, 1, 3, 3, 0);
    check("full_wb_ready", 32'(issue_ready), 32'd1);

    step(1, 0, 1, 5, 0, 0, 0, 5);
    step(1, 0, 0, 0, 1, 5, 0, 5);
    check("pv5_cleared", 32'(pending_vec[5]), 32'd0);

    step(1, 0, 0, 0, 1, 9, 9, 0);
    check("underflow_set", 32'(underflow_err), 32'd1);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    check("underflow_after_flush", 32'(underflow_err), 32'd1);

    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0);
    check("wb_zero_no_err", 32'(underflow_err), 32'd0);

    repeat (5) step(1, 0, 1, 0, 0, 0, 0, 0);
    check("zero_pending", 32'(pending_vec[0]), 32'd0);
    check("zero_ready", 32'(issue_ready), 32'd1);
    check("zero_busy", 32'(rs1_busy), 32'd0);

    step(1, 0, 1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 2, 0, 0, 0, 0);
    step(1, 0, 1, 4, 0, 0, 0, 0);
    step(1, 1, 1, 6, 0, 0, 0, 0);
    check("flush_pending", pending_vec, 32'h0);

    step(1, 0, 1, 8, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 11, 0, 0);
    step(0, 0, 1, 8, 1, 8, 8, 8);
    check("midreset_pending", pending_vec, 32'h0);
    check("midreset_uf", 32'(underflow_err), 32'd0);

    for (int n = 0; n < 1500; n++) begin
      bit r_n, fl, iv, wv;
      int ird, wrd, rs1, rs2;
      r_n = ($urandom_range(0, 99) != 0);
      fl  = ($urandom_range(0, 39) == 0);
      iv  = ($urandom_range(0, 9) < 6);
      wv  = !fl && ($urandom_range(0, 1) == 1);
      ird = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
      wrd = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
      rs1 = ($urandom_range(0, 1) == 1) ? wrd : int'($urandom_range(0, 7));
      rs2 = int'($urandom_range(0, 7));
      step(r_n, fl, iv, ird, wv, wrd, rs1, rs2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
